// File: rtl/truth_table_sequencer_if.sv
// Bundle between the run controller, the sequencer and the combinational function under test.
// master drives start and returns the function output; slave is the sequencer itself.
interface truth_table_sequencer_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic [N_IN-1:0]      dut_in;
  logic                 dut_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic [N_IN-1:0]      first_fail;
  logic [2**N_IN-1:0]   captured;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail, captured
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail, captured
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks every input code of an N_IN-input function, holds each SETTLE cycles, samples the
// output and compares it against a golden truth table.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | applying codes 0..2**N_IN-1, sampling at the end of each hold
// DONE   | results frozen until the next start
module truth_table_sequencer #(
  parameter int                 N_IN     = 4,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 16'hA5C3
) (
  input logic                     clk,
  input logic                     rst,
  truth_table_sequencer_if.slave  bus
);
  localparam int NV = 2**N_IN;
  localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HW-1:0] RELOAD = HW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NV-1:0]     captured_q, captured_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch;
  logic              last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      captured_q <= '0;
      err_q      <= '0;
      ff_q       <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    captured_d = captured_q;
    err_d      = err_q;
    ff_d       = ff_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mismatch   = (bus.dut_out != EXPECTED[idx_q]);
    last       = (idx_q == N_IN'(NV - 1));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_RUN;
          idx_d      = '0;
          hold_d     = RELOAD;
          captured_d = '0;
          err_d      = '0;
          ff_d       = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else begin
          captured_d[idx_q] = bus.dut_out;
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (err_q == '0) ff_d = idx_q;
          end
          // dut_in mirrors idx, so the last code stays applied in DONE
          if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d  = idx_q + N_IN'(1);
            hold_d = RELOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dut_in     = idx_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
  assign bus.captured   = captured_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: each run pushes its expected results; a monitor pops them when done rises
// and also tracks the applied code sequence while busy.
module tb_truth_table_sequencer;
  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int NV     = 2**N_IN;
  localparam logic [15:0] GOLD = 16'hA5C3;

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        pass;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] model_tbl;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];

  truth_table_sequencer_if #(.N_IN(N_IN)) bus ();

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(GOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb bus.dut_out = model_tbl[bus.dut_in];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // done is observed on the negedge after the edge 2**N_IN*SETTLE cycles past the start edge
  task automatic push_exp(input logic [15:0] cap, input logic [4:0] err,
                          input logic [3:0] ff, input logic pass);
    exp_t e;
    e.cap = cap; e.err = err; e.ff = ff; e.pass = pass;
    e.done_cyc = cyc + NV*SETTLE + 1;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // monitor
  initial begin
    int   run_base = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy && !busy_prev) run_base = cyc;
      if (bus.busy) check("dut_in_seq", 32'(bus.dut_in), 32'((cyc - run_base) / SETTLE));
      if (bus.done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("captured",   32'(bus.captured),   32'(e.cap));
          check("err_count",  32'(bus.err_count),  32'(e.err));
          check("first_fail", 32'(bus.first_fail), 32'(e.ff));
          check("pass",       32'(bus.pass),       32'(e.pass));
          check("done_cycle", 32'(cyc),            32'(e.done_cyc));
          check("last_code",  32'(bus.dut_in),     32'(NV - 1));
          check("busy_at_done", 32'(bus.busy),     32'd0);
        end
      end
      busy_prev = bus.busy;
      done_prev = bus.done;
    end
  end

  initial begin
    bus.start = 1'b0;
    model_tbl = GOLD;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_done",     32'(bus.done),      32'd0);
    check("rst_pass",     32'(bus.pass),      32'd0);
    check("rst_dut_in",   32'(bus.dut_in),    32'd0);
    check("rst_captured", 32'(bus.captured),  32'd0);
    check("rst_err",      32'(bus.err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // correct model
    push_exp(16'hA5C3, 5'd0, 4'd0, 1'b1);
    pulse_start();
    wait_done();

    // codes 5 and 12 inverted
    model_tbl = GOLD ^ 16'h1020;
    push_exp(16'hB5E3, 5'd2, 4'd5, 1'b0);
    pulse_start();
    wait_done();
    repeat (5) @(negedge clk);
    check("done_hold_err", 32'(bus.err_count), 32'd2);

    // rerun from DONE with the correct model: results clear at the start edge
    model_tbl = GOLD;
    push_exp(16'hA5C3, 5'd0, 4'd0, 1'b1);
    pulse_start();
    check("clr_done", 32'(bus.done),       32'd0);
    check("clr_pass", 32'(bus.pass),       32'd0);
    check("clr_err",  32'(bus.err_count),  32'd0);
    check("clr_ff",   32'(bus.first_fail), 32'd0);
    check("clr_cap",  32'(bus.captured),   32'd0);
    check("clr_busy", 32'(bus.busy),       32'd1);
    wait_done();

    // output tied low
    model_tbl = 16'h0000;
    push_exp(16'h0000, 5'd8, 4'd0, 1'b0);
    pulse_start();
    wait_done();

    // start pulses mid-run must be ignored
    model_tbl = GOLD;
    push_exp(16'hA5C3, 5'd0, 4'd0, 1'b1);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (11) @(negedge clk);
    pulse_start();
    wait_done();

    // start held through a whole run and across the completion edge
    push_exp(16'hA5C3, 5'd0, 4'd0, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200 && !bus.done; i++) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("held_start_done", 32'(bus.done), 32'd1);
    check("held_start_busy", 32'(bus.busy), 32'd0);

    // reset mid-run at code 7
    push_exp(16'h0000, 5'd0, 4'd0, 1'b0);
    pulse_start();
    for (int i = 0; i < 100 && bus.dut_in != 4'd7; i++) @(negedge clk);
    check("reached_code7", 32'(bus.dut_in), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("mid_rst_busy",   32'(bus.busy),      32'd0);
    check("mid_rst_done",   32'(bus.done),      32'd0);
    check("mid_rst_dut_in", 32'(bus.dut_in),    32'd0);
    check("mid_rst_cap",    32'(bus.captured),  32'd0);
    check("mid_rst_err",    32'(bus.err_count), 32'd0);
    @(negedge clk);
    push_exp(16'hA5C3, 5'd0, 4'd0, 1'b1);
    pulse_start();
    wait_done();

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
